// File: rtl/fetch_pc_unit_if.sv
// Fetch-unit handshake bundle: PC redirect in, instruction-memory request/response, decode-side buffer head.
interface fetch_pc_unit_if;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_pc;
    logic [31:0] if_instr;

    // The fetch unit drives the request and the buffer head.
    modport master (
        input  redirect,
        input  redirect_pc,
        output imem_req,
        output imem_addr,
        input  imem_ready,
        input  imem_rvalid,
        input  imem_rdata,
        output if_valid,
        input  if_ready,
        output if_pc,
        output if_instr
    );

    modport slave (
        output redirect,
        output redirect_pc,
        input  imem_req,
        input  imem_addr,
        output imem_ready,
        output imem_rvalid,
        output imem_rdata,
        input  if_valid,
        output if_ready,
        input  if_pc,
        input  if_instr
    );
endinterface

// File: rtl/fetch_pc_unit.sv
// RV32I program counter and fetch sequencer: one outstanding word fetch, redirect/flush handling,
// and a small in-order buffer of {pc, instruction} pairs for decode.
module fetch_pc_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned DEPTH    = 2
) (
    input logic             clk,
    input logic             rst_n,
    fetch_pc_unit_if.master bus
);

    localparam int unsigned PTR_W = (DEPTH > 2) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    typedef enum logic {
        S_REQ  = 1'b0,
        S_WAIT = 1'b1
    } state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } entry_t;

    state_e             state_q,   state_d;
    logic [31:0]        pc_q,      pc_d;
    logic [31:0]        req_pc_q,  req_pc_d;
    logic               discard_q, discard_d;
    logic [PTR_W-1:0]   head_q,    head_d;
    logic [PTR_W-1:0]   tail_q,    tail_d;
    logic [CNT_W-1:0]   count_q,   count_d;
    entry_t             fifo_q [DEPTH];

    logic               fifo_full;
    logic               fifo_empty;
    logic               accept;
    logic               rsp;
    logic               push;
    logic               pop;
    entry_t             head_entry;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign fifo_full  = (count_q == CNT_W'(DEPTH));
    assign fifo_empty = (count_q == '0);
    assign head_entry = fifo_q[head_q];

    // Request depends only on registered state so redirect never glitches the bus.
    assign bus.imem_req  = (state_q == S_REQ) && !fifo_full && rst_n;
    assign bus.imem_addr = pc_q;
    assign bus.if_valid  = !fifo_empty && rst_n;
    assign bus.if_pc     = bus.if_valid ? head_entry.pc    : '0;
    assign bus.if_instr  = bus.if_valid ? head_entry.instr : '0;

    assign accept = bus.imem_req && bus.imem_ready;
    assign rsp    = (state_q == S_WAIT) && bus.imem_rvalid;
    assign push   = rsp && !discard_q && !bus.redirect && rst_n;
    assign pop    = bus.if_valid && bus.if_ready && !bus.redirect;

    // Next-state: redirect outranks accept, response, push and pop.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        req_pc_d  = req_pc_q;
        discard_d = discard_q;
        head_d    = head_q;
        tail_d    = tail_q;
        count_d   = count_q;

        if (bus.redirect) begin
            pc_d    = {bus.redirect_pc[31:2], 2'b00};
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
            unique case (state_q)
                S_REQ: begin
                    if (accept) begin
                        req_pc_d  = pc_q;
                        state_d   = S_WAIT;
                        discard_d = 1'b1;
                    end
                end
                S_WAIT: begin
                    if (bus.imem_rvalid) begin
                        state_d   = S_REQ;
                        discard_d = 1'b0;
                    end else begin
                        discard_d = 1'b1;
                    end
                end
                default: ;
            endcase
        end else begin
            unique case (state_q)
                S_REQ: begin
                    if (accept) begin
                        req_pc_d = pc_q;
                        pc_d     = pc_q + 32'd4;
                        state_d  = S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (bus.imem_rvalid) begin
                        state_d   = S_REQ;
                        discard_d = 1'b0;
                    end
                end
                default: ;
            endcase

            if (push) begin
                tail_d = ptr_inc(tail_q);
            end
            if (pop) begin
                head_d = ptr_inc(head_q);
            end
            unique case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_REQ;
            pc_q      <= {RESET_PC[31:2], 2'b00};
            req_pc_q  <= '0;
            discard_q <= 1'b0;
            head_q    <= '0;
            tail_q    <= '0;
            count_q   <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            req_pc_q  <= req_pc_d;
            discard_q <= discard_d;
            head_q    <= head_d;
            tail_q    <= tail_d;
            count_q   <= count_d;
        end
    end

    // Buffer storage needs no reset; count gates visibility.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_q[tail_q] <= '{pc: req_pc_q, instr: bus.imem_rdata};
        end
    end

    // A response with nothing outstanding is a memory-side protocol error.
    a_no_rvalid_in_req : assert property (
        @(posedge clk) disable iff (!rst_n) !((state_q == S_REQ) && bus.imem_rvalid)
    );

endmodule

// File: doc/fetch_pc_unit.md
Name: fetch_pc_unit

Overview:
- Program-counter register and instruction-fetch sequencer for the RISCV32I core.
- Consumes the 32-bit next-PC selection produced by the PC-select mux: ctrl = branch taken, out = target, presented here as redirect/redirect_pc.
- Issues word fetches to instruction memory through a valid/ready handshake.
- Buffers returned instructions with their PCs in a small FIFO for decode.

Parameters:
RESET_PC, 32'h0000_0000, fetch address loaded on reset; bits [1:0] must be 0.
DEPTH, 2, instruction buffer entries; legal values 2..8.

Ports:
clk  input  1  clock; all state updates on rising edge
rst_n  input  1  synchronous active-low reset
redirect  input  1  taken branch/jump this cycle; flushes fetch
redirect_pc  input  32  new fetch address (output of PC-select mux)
imem_req  output  1  fetch request valid
imem_addr  output  32  word address of request
imem_ready  input  1  memory accepts request when imem_req && imem_ready
imem_rvalid  input  1  read data valid; at most one response per accepted request, in order, ≥1 cycle after accept
imem_rdata  input  32  instruction word
if_valid  output  1  buffer head valid
if_ready  input  1  decode consumes head when if_valid && if_ready
if_pc  output  32  PC of head instruction
if_instr  output  32  head instruction

Behaviour:
- Registers:
  - pc: next address to fetch.
  - req_pc: address in flight.
  - state: S_REQ or S_WAIT.
  - discard flag.
  - FIFO storage, head, tail and count.
- Reset (rst_n=0 at edge):
  - pc=RESET_PC, state=S_REQ, discard=0, count=0.
  - While rst_n=0, imem_req=0 and if_valid=0.
  - Reset mid-transaction drops the outstanding response. Memory must not return rvalid for requests accepted before reset.
- imem_req = (state==S_REQ) && (count<DEPTH) && rst_n.
  - Depends only on registered state, never combinationally on redirect.
  - imem_addr = pc.
- if_valid = (count!=0). if_pc and if_instr come from the head entry and are 0 when empty.
- At most one outstanding request.
- S_REQ:
  - On accept: req_pc<=pc; pc<=pc+4 (mod 2^32, so 32'hFFFF_FFFC wraps to 0); state<=S_WAIT.
  - Otherwise hold.
- S_WAIT:
  - On imem_rvalid with discard=0: push {req_pc, imem_rdata}; state<=S_REQ.
  - On imem_rvalid with discard=1: drop the data; discard<=0; state<=S_REQ.
- FIFO:
  - Push never occurs when full; guaranteed because requests issue only when count<DEPTH.
  - Simultaneous push and pop leaves count unchanged; pointers wrap modulo DEPTH.
- Redirect takes priority over every other event in the same cycle:
  - pc <= {redirect_pc[31:2], 2'b00}; FIFO flushed (count=0, pointers reset). A same-cycle pop and a same-cycle push are both ignored.
  - In S_WAIT without same-cycle rvalid: discard<=1, stay in S_WAIT.
  - In S_WAIT with same-cycle rvalid: response dropped; state<=S_REQ; discard<=0.
  - In S_REQ with same-cycle accept: the accepted request becomes stale; state<=S_WAIT, discard<=1; pc takes redirect_pc, not +4.
  - In S_REQ without accept: state stays S_REQ.
  - First request to the new PC is presented the cycle after the redirect, or after the stale response is drained.
- Back-to-back redirects: the last one wins; discard stays 1 until the single stale response arrives.
- Latency:
  - Accept at cycle t with rvalid at t+k gives if_valid at t+k+1.
  - Next request issued at t+k+1 if FIFO not full.
- imem_rvalid in S_REQ is a protocol violation; ignore it and assert in simulation.

Test Plan:
- Reset with RESET_PC=0x100, imem_ready=1, 1-cycle rvalid, if_ready=1 -> fetches 0x100, 0x104, 0x108 in order; if_pc/if_instr match the returned words; imem_req=0 during reset.
- if_ready=0 with DEPTH=2 -> exactly 2 requests accepted (0x0, 0x4); imem_req then stays 0. Raising if_ready pops 0x0, then req for 0x8 appears the next cycle.
- Redirect to 0x200 while in S_WAIT for 0x10; response arrives 3 cycles later -> that response dropped, FIFO empty, next imem_addr=0x200, first if_pc=0x200.
- Redirect to 0x300 in the same cycle as rvalid for 0x20 and a same-cycle pop -> nothing pushed, count=0, next request 0x300 issued the following cycle.
- Redirect to 0xFFFF_FFFE (misaligned) -> first imem_addr=0xFFFF_FFFC; next 0x0000_0000 (wrap).
- Redirect in the same cycle a request for 0x40 is accepted -> the 0x40 response is discarded; following request address is redirect_pc; no entry with if_pc=0x40 ever appears.
